// File: rtl/vram_pkg.sv
// vram_pkg: shared constants and types for the video RAM write-port sequencer.
// Optional feature macro used by this slice: VRAM_FILL_INCR_EN (ramp fill data).
package vram_pkg;

    // Default geometry; must match the videoram instance.
    localparam int VRAM_AWIDTH = 8;
    localparam int VRAM_DWIDTH = 16;

    // Block-fill engine states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } fill_state_e;

    // Word count for the default geometry: 0 .. 2**VRAM_AWIDTH inclusive.
    typedef logic [VRAM_AWIDTH:0] vram_count_t;

endpackage

// File: rtl/vram_fill_seq.sv
// vram_fill_seq: block-fill engine for the video RAM write port.
// Latches base/count/value on fill_start, then offers one write per cycle
// through fill_valid; the arbiter accepts it with fill_grant.
// Macro VRAM_FILL_INCR_EN: when defined, the fill word increments after
// each granted write (ramp pattern); otherwise it stays constant.
module vram_fill_seq
    import vram_pkg::*;
#(
    parameter int AWIDTH = VRAM_AWIDTH,
    parameter int DWIDTH = VRAM_DWIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fill_start,
    input  logic [AWIDTH-1:0] fill_base,
    input  logic [AWIDTH:0]   fill_count,
    input  logic [DWIDTH-1:0] fill_value,
    input  logic              fill_grant,
    output logic              fill_valid,
    output logic [AWIDTH-1:0] fill_addr,
    output logic [DWIDTH-1:0] fill_data,
    output logic              fill_busy,
    output logic              fill_done
);

    localparam logic [AWIDTH:0]   CNT_ZERO = {(AWIDTH+1){1'b0}};
    localparam logic [AWIDTH:0]   CNT_ONE  = (AWIDTH+1)'(1'b1);
    localparam logic [AWIDTH-1:0] ADDR_ONE = AWIDTH'(1'b1);

    fill_state_e       state_r;
    fill_state_e       next_state_s;
    logic [AWIDTH-1:0] addr_r;
    logic [AWIDTH:0]   cnt_r;
    logic [DWIDTH-1:0] value_r;
    logic              busy_r;
    logic              done_r;

    // Next-state logic: a zero-length fill goes straight to DONE; the last granted write ends FILL.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (fill_start) begin
                    if (fill_count == CNT_ZERO) begin
                        next_state_s = ST_DONE;
                    end else begin
                        next_state_s = ST_FILL;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (fill_grant && (cnt_r == CNT_ONE)) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_FILL;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register plus busy/done flags registered from the next state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s != ST_IDLE);
            done_r  <= (next_state_s == ST_DONE);
        end
    end

    // Fill parameters: latched only when idle, stepped once per granted write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r  <= {AWIDTH{1'b0}};
            cnt_r   <= CNT_ZERO;
            value_r <= {DWIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (fill_start) begin
                        addr_r  <= fill_base;
                        cnt_r   <= fill_count;
                        value_r <= fill_value;
                    end
                end
                ST_FILL: begin
                    if (fill_grant) begin
                        // Address wraps naturally modulo 2**AWIDTH.
                        addr_r <= addr_r + ADDR_ONE;
                        cnt_r  <= cnt_r - CNT_ONE;
`ifdef VRAM_FILL_INCR_EN
                        value_r <= value_r + DWIDTH'(1'b1);
`else
                        value_r <= value_r;
`endif
                    end
                end
                default: begin
                    addr_r  <= addr_r;
                    cnt_r   <= cnt_r;
                    value_r <= value_r;
                end
            endcase
        end
    end

    assign fill_valid = (state_r == ST_FILL);
    assign fill_addr  = addr_r;
    assign fill_data  = value_r;
    assign fill_busy  = busy_r;
    assign fill_done  = done_r;

endmodule

// File: rtl/vram_write_arb.sv
// vram_write_arb: owns the videoram write port and shares it between a CPU
// single-word requester and the block-fill engine (vram_fill_seq).
// The CPU has priority but is ineligible while its ack is high, so the fill
// engine always gets at least every other slot.
// Macro VRAM_FILL_INCR_EN (in vram_fill_seq) selects ramp fill data.
module vram_write_arb
    import vram_pkg::*;
#(
    parameter int AWIDTH = VRAM_AWIDTH,
    parameter int DWIDTH = VRAM_DWIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic [AWIDTH-1:0] cpu_addr,
    input  logic [DWIDTH-1:0] cpu_data,
    output logic              cpu_ack,
    input  logic              fill_start,
    input  logic [AWIDTH-1:0] fill_base,
    input  logic [AWIDTH:0]   fill_count,
    input  logic [DWIDTH-1:0] fill_value,
    output logic              fill_busy,
    output logic              fill_done,
    output logic              vram_we,
    output logic [AWIDTH-1:0] vram_waddr,
    output logic [DWIDTH-1:0] vram_wdata
);

    logic              cpu_elig_s;
    logic              fill_valid_s;
    logic              fill_grant_s;
    logic [AWIDTH-1:0] fill_addr_s;
    logic [DWIDTH-1:0] fill_data_s;

    logic              cpu_ack_r;
    logic              vram_we_r;
    logic [AWIDTH-1:0] vram_waddr_r;
    logic [DWIDTH-1:0] vram_wdata_r;

    vram_fill_seq #(
        .AWIDTH (AWIDTH),
        .DWIDTH (DWIDTH)
    ) u_fill_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .fill_start (fill_start),
        .fill_base  (fill_base),
        .fill_count (fill_count),
        .fill_value (fill_value),
        .fill_grant (fill_grant_s),
        .fill_valid (fill_valid_s),
        .fill_addr  (fill_addr_s),
        .fill_data  (fill_data_s),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done)
    );

    // Arbitration on registered state: an un-acked CPU request beats the fill engine.
    always_comb begin
        cpu_elig_s   = 1'b0;
        fill_grant_s = 1'b0;
        if (cpu_req && !cpu_ack_r) begin
            cpu_elig_s   = 1'b1;
            fill_grant_s = 1'b0;
        end else begin
            cpu_elig_s   = 1'b0;
            fill_grant_s = fill_valid_s;
        end
    end

    // Write-port register: drive the winner next cycle, otherwise drop we and hold addr/data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_ack_r    <= 1'b0;
            vram_we_r    <= 1'b0;
            vram_waddr_r <= {AWIDTH{1'b0}};
            vram_wdata_r <= {DWIDTH{1'b0}};
        end else begin
            cpu_ack_r <= cpu_elig_s;
            if (cpu_elig_s) begin
                vram_we_r    <= 1'b1;
                vram_waddr_r <= cpu_addr;
                vram_wdata_r <= cpu_data;
            end else if (fill_grant_s) begin
                vram_we_r    <= 1'b1;
                vram_waddr_r <= fill_addr_s;
                vram_wdata_r <= fill_data_s;
            end else begin
                vram_we_r    <= 1'b0;
                vram_waddr_r <= vram_waddr_r;
                vram_wdata_r <= vram_wdata_r;
            end
        end
    end

    assign cpu_ack    = cpu_ack_r;
    assign vram_we    = vram_we_r;
    assign vram_waddr = vram_waddr_r;
    assign vram_wdata = vram_wdata_r;

endmodule

// File: doc/vram_write_arb.md
Name: vram_write_arb

Overview:
- Sequencer and arbiter for the video RAM write port (wclk/we/waddr/wdata).
- Shares the port between a CPU single-word requester and a hardware block-fill engine (screen clear, region fill).
- Sits between the CPU bus bridge and the videoram instance.
- Owns the write port only; the read/scanout side is untouched.

Parameters:
AWIDTH, 8, video RAM address width; must match the videoram instance
DWIDTH, 16, video RAM data width; must match the videoram instance

Ports:
clk  in  1  single clock; also drives videoram wclk
rst_n  in  1  asynchronous active-low reset
cpu_req  in  1  level request; held until cpu_ack
cpu_addr  in  AWIDTH  CPU write address, stable while cpu_req high
cpu_data  in  DWIDTH  CPU write data, stable while cpu_req high
cpu_ack  out  1  one-cycle pulse; the write is on the port this cycle
fill_start  in  1  one-cycle pulse; starts a fill
fill_base  in  AWIDTH  first fill address, sampled on fill_start
fill_count  in  AWIDTH+1  number of words, 0..2**AWIDTH, sampled on fill_start
fill_value  in  DWIDTH  fill word, sampled on fill_start
fill_busy  out  1  high while a fill is in progress
fill_done  out  1  one-cycle pulse when a fill completes
vram_we  out  1  videoram we
vram_waddr  out  AWIDTH  videoram waddr
vram_wdata  out  DWIDTH  videoram wdata

Behaviour:
- All outputs are registered.
- Reset values: cpu_ack=0, fill_busy=0, fill_done=0, vram_we=0, vram_waddr=0, vram_wdata=0.
- Reset also forces the fill engine to IDLE.
- Fill engine states:
  - IDLE -> FILL on fill_start with fill_count!=0.
  - IDLE -> DONE on fill_start with fill_count==0; no writes are issued.
  - FILL -> DONE when the remaining count reaches 0 after a granted fill write.
  - DONE -> IDLE unconditionally; fill_done=1 for exactly this one cycle.
- fill_start is ignored outside IDLE; latched parameters are not disturbed.
- Arbitration is decided every cycle on registered state:
  - The CPU is eligible when cpu_req=1 and cpu_ack=0 (this cycle).
  - An eligible CPU wins over the fill engine.
  - Otherwise, in FILL, the fill engine wins.
  - Otherwise nothing is written: vram_we=0 next cycle, and addr/data hold their previous values.
- Latency:
  - CPU grant decided in cycle N -> cycle N+1 has vram_we=1, vram_waddr=cpu_addr, vram_wdata=cpu_data, cpu_ack=1.
  - The requester drops cpu_req, or presents a new request, after sampling cpu_ack.
  - Because the CPU is not eligible while cpu_ack=1, a held request never double-writes.
  - Maximum CPU rate is 1 write per 2 cycles, which guarantees the fill engine at least every other slot.
- Fill writes:
  - Each granted fill write drives vram_we=1, vram_waddr=current address, vram_wdata=value.
  - Address increments by 1, wrapping modulo 2**AWIDTH (base=0xFE, count=4 -> FE, FF, 00, 01).
  - Remaining count decrements by 1 per write.
  - Throughput is 1 word/cycle when the CPU is idle.
- fill_busy=1 from the cycle after fill_start until the cycle of fill_done inclusive.
- If fill_start and an eligible cpu_req occur in the same cycle, the fill is latched and the CPU write is granted; no interaction.
- fill_count=2**AWIDTH fills the whole RAM exactly once.
- Reset mid-fill:
  - Asynchronously aborts the fill; no fill_done pulse.
  - vram_we drops immediately.
  - A CPU request pending at reset is lost; the requester re-issues it.

Optional Feature:
- Macro VRAM_FILL_INCR_EN.
- Defined: the fill word increments by 1 (mod 2**DWIDTH) after each fill write, giving a ramp pattern starting at fill_value for test screens.
- Undefined: every fill write uses the constant fill_value.

Decomposition:
- Package vram_pkg holds:
  - default AWIDTH/DWIDTH constants;
  - the fill state enum (IDLE, FILL, DONE);
  - a typedef for the AWIDTH+1-bit count.
- One natural sub-module, vram_fill_seq, holds the fill FSM, address/count/value registers and the optional increment.
- vram_fill_seq has a fill_valid/fill_grant handshake toward the arbiter.

Test Plan:
- Single CPU write: cpu_req addr=0x12 data=0xBEEF -> one cycle later vram_we=1, waddr=0x12, wdata=0xBEEF, cpu_ack=1; exactly one write even with req held 3 cycles (second write only after ack-gap cycle).
- Fill with wrap: fill_start base=0xFE count=4 value=0x5A5A, CPU idle -> writes FE, FF, 00, 01 on 4 consecutive cycles; fill_done one cycle after last write; fill_busy high for 5 cycles.
- Contention: fill count=6 with cpu_req held continuously (new addr after each ack) -> CPU and fill writes alternate, all 6 fill words written, no CPU write lost or duplicated.
- Zero count and busy start: fill_start count=0 -> no vram_we, fill_done pulse; fill_start during active fill -> ignored, original base/count complete.
- Reset mid-fill: rst_n low after 3 of 10 writes -> all outputs 0 asynchronously, no fill_done; a new fill after reset runs from its own base.
- With VRAM_FILL_INCR_EN: base=0 count=3 value=0xFFFF -> wdata FFFF, 0000, 0001.
